tx_pattern_sched: RTL and testbench

TX_PATTERN_SCHED -- requirements
Module: tx_pattern_sched

---
 rtl/tx_pattern_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_tx_pattern_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pattern_sched.sv
// ---------------------------------------------------------------------------
// tx_pattern_sched
// Burst/gap scheduler that streams test patterns toward a radio TX path.
// A run is a sequence of bursts of burst_len samples separated by gap_len
// idle cycles; it ends after num_bursts bursts (0 = continuous) or after
// the burst in flight when stop is raised.
//
// Ports
//   radio_clk    : clock, all logic on the rising edge
//   radio_rst    : asynchronous active-high reset
//   start        : one-cycle run request (honoured only in IDLE)
//   stop         : level request to end the run after the current burst
//   pattern_sel  : 0 zeros, 1 toggle, 2 ramp, 3 constant
//   const_iq     : constant sample for pattern 3 (I [31:16], Q [15:0])
//   burst_len    : samples per burst
//   gap_len      : idle cycles between bursts
//   num_bursts   : bursts per run, 0 = continuous
//   tx_data      : sample output (I [31:16], Q [15:0])
//   tx_valid     : sample valid
//   tx_ready     : downstream accept
//   tx_last      : last sample of a burst
//   busy         : scheduler not idle
//   done         : one-cycle pulse when a run ends
//   bursts_sent  : completed bursts in the current or last run
// ---------------------------------------------------------------------------
module tx_pattern_sched #(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic              radio_clk,
    input  logic              radio_rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        pattern_sel,
    input  logic [31:0]       const_iq,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [LEN_W-1:0]  gap_len,
    input  logic [CNT_W-1:0]  num_bursts,
    output logic [31:0]       tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bursts_sent
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned HALF_W  = 16;
    localparam logic [DATA_W-1:0] TOGGLE_WORD = 32'hAAAA_AAAA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [LEN_W-1:0]    idx_q,     idx_d;
    logic [LEN_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]    bursts_q,  bursts_d;
    logic [1:0]          sel_q,     sel_d;
    logic [DATA_W-1:0]   const_q,   const_d;
    logic [LEN_W-1:0]    len_q,     len_d;
    logic [LEN_W-1:0]    gap_q,     gap_d;
    logic [CNT_W-1:0]    nb_q,      nb_d;
    logic [DATA_W-1:0]   data_q,    data_d;
    logic                valid_q,   valid_d;
    logic                last_q,    last_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;

    // Sample generator: pure function of pattern, constant and sample index.
    function automatic logic [DATA_W-1:0] pattern_word(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] cval,
        input logic [HALF_W-1:0] idx
    );
        logic [DATA_W-1:0] w;
        w = '0;
        case (sel)
            2'd0: w = '0;
            2'd1: w = idx[1] ? TOGGLE_WORD : '0;
            2'd2: w = {idx, ~idx};
            default: w = cval;
        endcase
        return w;
    endfunction

    // State and output registers.
    always_ff @(posedge radio_clk or posedge radio_rst) begin
        if (radio_rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            bursts_q  <= '0;
            sel_q     <= '0;
            const_q   <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            nb_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
            bursts_q  <= bursts_d;
            sel_q     <= sel_d;
            const_q   <= const_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            nb_q      <= nb_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_cnt_d = gap_cnt_q;
        bursts_d  = bursts_q;
        sel_d     = sel_q;
        const_d   = const_q;
        len_d     = len_q;
        gap_d     = gap_q;
        nb_d      = nb_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                // stop overrides start; a zero-length burst is meaningless
                if (start && !stop && (burst_len != '0)) begin
                    sel_d     = pattern_sel;
                    const_d   = const_iq;
                    len_d     = burst_len;
                    gap_d     = gap_len;
                    nb_d      = num_bursts;
                    idx_d     = '0;
                    gap_cnt_d = '0;
                    bursts_d  = '0;
                    state_d   = BURST;
                    valid_d   = 1'b1;
                    data_d    = pattern_word(pattern_sel, const_iq, '0);
                    last_d    = (burst_len == LEN_W'(1));
                end
            end

            BURST: begin
                if (valid_q && tx_ready) begin
                    if (last_q) begin
                        bursts_d = CNT_W'(bursts_q + CNT_W'(1));
                        idx_d    = '0;
                        if (stop || ((nb_q != '0) &&
                                     (CNT_W'(bursts_q + CNT_W'(1)) == nb_q))) begin
                            state_d = FIN;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (gap_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                            valid_d   = 1'b0;
                            last_d    = 1'b0;
                        end else begin
                            // back-to-back burst, no bubble
                            valid_d = 1'b1;
                            data_d  = pattern_word(sel_q, const_q, '0);
                            last_d  = (len_q == LEN_W'(1));
                        end
                    end else begin
                        idx_d  = LEN_W'(idx_q + LEN_W'(1));
                        data_d = pattern_word(sel_q, const_q,
                                              HALF_W'(LEN_W'(idx_q + LEN_W'(1))));
                        last_d = (LEN_W'(idx_q + LEN_W'(1)) == LEN_W'(len_q - LEN_W'(1)));
                    end
                end
            end

            GAP: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (stop) begin
                    state_d   = FIN;
                    gap_cnt_d = '0;
                    done_d    = 1'b1;
                end else if (gap_cnt_q == LEN_W'(gap_q - LEN_W'(1))) begin
                    state_d   = BURST;
                    gap_cnt_d = '0;
                    valid_d   = 1'b1;
                    data_d    = pattern_word(sel_q, const_q, '0);
                    last_d    = (len_q == LEN_W'(1));
                end else begin
                    gap_cnt_d = LEN_W'(gap_cnt_q + LEN_W'(1));
                end
            end

            default: begin
                // FIN: done is high for this single cycle
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign tx_data     = data_q;
    assign tx_valid    = valid_q;
    assign tx_last     = last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bursts_sent = bursts_q;

endmodule

// File: tb/tb_tx_pattern_sched.sv
// ---------------------------------------------------------------------------
// tb_tx_pattern_sched
// Self-checking bench: a cycle-level behavioural model of the scheduler
// (phase / remaining counts) is compared to the DUT every cycle, plus
// literal expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_tx_pattern_sched;

    logic        radio_clk = 1'b0;
    logic        radio_rst;
    logic        start;
    logic        stop;
    logic [1:0]  pattern_sel;
    logic [31:0] const_iq;
    logic [15:0] burst_len;
    logic [15:0] gap_len;
    logic [7:0]  num_bursts;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic        done;
    logic [7:0]  bursts_sent;

    tx_pattern_sched #(.LEN_W(16), .CNT_W(8)) dut (
        .radio_clk   (radio_clk),
        .radio_rst   (radio_rst),
        .start       (start),
        .stop        (stop),
        .pattern_sel (pattern_sel),
        .const_iq    (const_iq),
        .burst_len   (burst_len),
        .gap_len     (gap_len),
        .num_bursts  (num_bursts),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .busy        (busy),
        .done        (done),
        .bursts_sent (bursts_sent)
    );

    always #5 radio_clk = ~radio_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 sending burst, 2 gap, 3 finishing
    int          m_phase = 0;
    int          m_idx   = 0;
    int          m_gap   = 0;
    logic [7:0]  m_bs    = '0;
    int          c_sel = 0, c_len = 0, c_gl = 0, c_nb = 0;
    logic [31:0] c_const = '0;

    int          cyc = 0;
    logic [31:0] xd[$];
    bit          xl[$];
    int          xc[$];
    int          done_cnt = 0;

    function automatic logic [31:0] exp_data(input int sel, input logic [31:0] c, input int idx);
        int r;
        r = idx % 65536;
        case (sel)
            0: return 32'h0;
            1: return (((idx / 2) % 2) == 1) ? 32'hAAAA_AAAA : 32'h0;
            2: return {16'(r), 16'(65535 - r)};
            default: return c;
        endcase
    endfunction

    always @(posedge radio_clk or posedge radio_rst) begin
        if (radio_rst) begin
            m_phase = 0; m_idx = 0; m_gap = 0; m_bs = '0;
        end else begin
            cyc++;
            if (tx_valid && tx_ready) begin
                xd.push_back(tx_data);
                xl.push_back(tx_last);
                xc.push_back(cyc);
            end
            case (m_phase)
                0: if (start && !stop && burst_len != 0) begin
                    c_sel = int'(pattern_sel); c_const = const_iq;
                    c_len = int'(burst_len); c_gl = int'(gap_len); c_nb = int'(num_bursts);
                    m_idx = 0; m_bs = '0; m_phase = 1;
                end
                1: if (tx_ready) begin
                    if (m_idx == c_len - 1) begin
                        m_idx = 0;
                        m_bs  = m_bs + 8'd1;
                        if (stop || (c_nb != 0 && int'(m_bs) == c_nb)) m_phase = 3;
                        else if (c_gl != 0) begin m_phase = 2; m_gap = c_gl; end
                    end else begin
                        m_idx++;
                    end
                end
                2: if (stop) m_phase = 3;
                   else begin
                       m_gap--;
                       if (m_gap == 0) m_phase = 1;
                   end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge radio_clk) begin
        chk("valid", 32'(tx_valid), 32'(m_phase == 1));
        chk("busy",  32'(busy),     32'(m_phase != 0));
        chk("done",  32'(done),     32'(m_phase == 3));
        chk("bursts_sent", 32'(bursts_sent), 32'(m_bs));
        if (m_phase == 1) begin
            chk("data", tx_data, exp_data(c_sel, c_const, m_idx));
            chk("last", 32'(tx_last), 32'(m_idx == c_len - 1));
        end
        if (done) done_cnt++;
    end

    // ---------------- stimulus ----------------
    int ready_mode = 0;   // 0 always 1, 1 toggle, 2 random
    int stop_cd    = 0;   // raise stop when this counts down to 0
    bit noise      = 0;   // random start / config wiggle while busy

    task automatic tick();
        @(posedge radio_clk);
        #1;
        start = 1'b0;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ~tx_ready;
            default: tx_ready = ($urandom_range(3) != 0);
        endcase
        if (stop_cd > 0) begin
            stop_cd--;
            if (stop_cd == 0) stop = 1'b1;
        end
        if (noise && m_phase != 0) begin
            burst_len   = 16'($urandom_range(7));
            gap_len     = 16'($urandom_range(3));
            num_bursts  = 8'($urandom_range(3));
            pattern_sel = 2'($urandom_range(3));
            const_iq    = $urandom;
            start       = ($urandom_range(7) == 0);
        end
    endtask

    task automatic clear_log();
        xd.delete(); xl.delete(); xc.delete(); done_cnt = 0;
    endtask

    task automatic cfg(input int sel, input logic [31:0] c, input int len, input int gl, input int nb);
        pattern_sel = 2'(sel); const_iq = c; burst_len = 16'(len);
        gap_len = 16'(gl); num_bursts = 8'(nb);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (m_phase != 0 && n < max) begin tick(); n++; end
        if (m_phase != 0) begin
            chk("run_timeout", 32'(n), 32'(max + 1));
            $display("FAIL run did not end, stopping");
            $fatal(1, "timeout");
        end
        tick();
        stop = 1'b0; stop_cd = 0;
    endtask

    logic [31:0] t1_exp [8];
    int          n;

    initial begin
        radio_rst = 1'b1; start = 1'b0; stop = 1'b0; tx_ready = 1'b1;
        cfg(0, 32'h0, 0, 0, 0);
        tick(); tick();
        chk("rst_valid", 32'(tx_valid), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_data",  tx_data, 32'h0);
        chk("rst_bursts", 32'(bursts_sent), 32'h0);

        // toggle pattern, single burst of 8, start right after reset release
        t1_exp = '{32'h0, 32'h0, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0, 32'h0, 32'hAAAAAAAA, 32'hAAAAAAAA};
        clear_log();
        cfg(1, 32'h0, 8, 0, 1);
        radio_rst = 1'b0; start = 1'b1;
        tick();
        chk("t1_first_valid", 32'(tx_valid), 32'h1);
        wait_idle(100);
        chk("t1_count", 32'(xd.size()), 32'd8);
        for (int i = 0; i < 8 && i < xd.size(); i++) begin
            chk("t1_data", xd[i], t1_exp[i]);
            chk("t1_last", 32'(xl[i]), 32'(i == 7));
        end
        chk("t1_bursts", 32'(bursts_sent), 32'd1);
        chk("t1_done", 32'(done_cnt), 32'd1);

        // ramp, 2 bursts of 4 with a 3-cycle gap
        clear_log();
        cfg(2, 32'h0, 4, 3, 2);
        start = 1'b1; tick();
        wait_idle(100);
        chk("t2_count", 32'(xd.size()), 32'd8);
        for (int i = 0; i < 8 && i < xd.size(); i++)
            chk("t2_data", xd[i], {16'(i % 4), 16'hFFFF - 16'(i % 4)});
        if (xc.size() == 8) chk("t2_gap", 32'(xc[4] - xc[3]), 32'd4);
        chk("t2_bursts", 32'(bursts_sent), 32'd2);

        // constant pattern with a stalling consumer
        clear_log();
        cfg(3, 32'h12345678, 5, 0, 1);
        ready_mode = 1; tx_ready = 1'b1;
        start = 1'b1; tick();
        wait_idle(100);
        ready_mode = 0;
        chk("t3_count", 32'(xd.size()), 32'd5);
        for (int i = 0; i < xd.size(); i++) begin
            chk("t3_data", xd[i], 32'h12345678);
            chk("t3_last", 32'(xl[i]), 32'(i == 4));
        end

        // continuous run stopped during the first sample of burst 3
        clear_log();
        cfg(0, 32'h0, 2, 1, 0);
        start = 1'b1; tick();
        n = 0;
        while (!(xd.size() == 4 && m_phase == 1) && n < 50) begin tick(); n++; end
        chk("t4_reach_b3", 32'(n < 50), 32'h1);
        stop = 1'b1;
        wait_idle(100);
        chk("t4_count", 32'(xd.size()), 32'd6);
        chk("t4_bursts", 32'(bursts_sent), 32'd3);
        chk("t4_done", 32'(done_cnt), 32'd1);

        // reset mid-burst
        clear_log();
        cfg(2, 32'h0, 20, 0, 1);
        start = 1'b1; tick();
        tick(); tick();
        #2 radio_rst = 1'b1;
        #1;
        chk("t5_valid", 32'(tx_valid), 32'h0);
        chk("t5_data",  tx_data, 32'h0);
        chk("t5_last",  32'(tx_last), 32'h0);
        chk("t5_busy",  32'(busy), 32'h0);
        chk("t5_done",  32'(done), 32'h0);
        chk("t5_bursts", 32'(bursts_sent), 32'h0);
        tick();
        radio_rst = 1'b0;
        tick();
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        clear_log();
        cfg(1, 32'h0, 3, 0, 1);
        start = 1'b1; tick();
        wait_idle(100);
        chk("t5_rerun", 32'(xd.size()), 32'd3);

        // rejected starts
        clear_log();
        cfg(0, 32'h0, 0, 0, 1);
        start = 1'b1; tick();
        cfg(0, 32'h0, 4, 0, 1);
        start = 1'b1; stop = 1'b1; tick();
        stop = 1'b0; tick(); tick();
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_count", 32'(xd.size()), 32'd0);

        // bursts_sent wraps in continuous mode
        clear_log();
        cfg(3, 32'hCAFEF00D, 1, 0, 0);
        start = 1'b1; tick();
        repeat (300) tick();
        stop = 1'b1;
        wait_idle(20);
        chk("t7_wrap", 32'(bursts_sent), 32'(8'(xd.size())));
        chk("t7_wrapped", 32'(xd.size() > 256), 32'h1);

        // randomized runs
        for (int r = 0; r < 40; r++) begin
            clear_log();
            ready_mode = 2;
            cfg($urandom_range(3), $urandom, $urandom_range(1, 6),
                $urandom_range(3), $urandom_range(3));
            if (num_bursts == 0 || $urandom_range(3) == 0) stop_cd = $urandom_range(2, 40);
            start = 1'b1;
            noise = 1'b1;
            tick();
            wait_idle(2000);
            noise = 1'b0;
            chk("rand_done", 32'(done_cnt), 32'd1);
            chk("rand_bursts", 32'(bursts_sent), 32'(8'(n_last(xl))));
            ready_mode = 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic int n_last(input bit q[$]);
        int k;
        k = 0;
        foreach (q[i]) if (q[i]) k++;
        return k;
    endfunction

endmodule
